pb_debounce_irq_ctrl: RTL and testbench
=======================================

Name: pb_debounce_irq_ctrl

Overview:
Memory-mapped controller for the board pushbuttons (active-low KEY inputs).
- Synchronises and debounces each button and records press events in a sticky edge-capture register.
- Raises a maskable interrupt to the HPS.
- Sits on the lightweight HPS-to-FPGA Avalon-MM bridge and replaces a bare input PIO for the buttons.

Parameters:
- WIDTH, 2, number of buttons (1..8).
- DEBOUNCE_CYCLES, 50000, consecutive cycles a synchronised input must differ from the stable value before it is accepted (1 ms at 50 MHz); minimum 2.
- CNT_W, 16, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset.
- address  in  2  Avalon word address.
- chipselect  in  1  Avalon select.
- write_n  in  1  Avalon write strobe, active-low.
- writedata  in  32  Avalon write data.
- readdata  out  32  Avalon read data, registered.
- in_port  in  WIDTH  raw button levels, asynchronous, 0 = pressed.
- irq  out  1  level interrupt, active-high.

Behaviour:
- Reset: reset_n, asynchronous, active-low; clock clk. Reset values:
  - readdata = 0, irq = 0.
  - Synchroniser flops = all 1s, stable = all 1s (released).
  - Debounce counters = 0, irq_mask = 0, edge_cap = 0.
- Synchroniser: two flops per bit; sync = second stage.
- Debounce, per bit, every cycle:
  - If sync == stable: counter <= 0.
  - Else if counter == DEBOUNCE_CYCLES-1: stable <= sync and counter <= 0.
  - Else: counter <= counter+1.
  - A bounce back to the stable value before expiry restarts counting from 0.
  - Latency from an in_port change held steady to stable update is exactly 2 + DEBOUNCE_CYCLES clock edges.
- Press detect: a bit's press event fires on the edge where that bit's stable goes 1 -> 0. Release (0 -> 1) produces no event.
- Register map (word offsets):
  - 0 DATA, RO: bits[WIDTH-1:0] = ~stable (1 = pressed); upper bits 0.
  - 1 IRQ_MASK, RW: bits[WIDTH-1:0]; upper bits ignored on write, read 0.
  - 2 EDGE_CAP, R/W1C: a bit sets on a press event. Writing 1 to a bit clears it; writing 0 leaves it unchanged.
  - 3 PRESS_CNT: see Optional Feature.
- Write: occurs when chipselect=1 and write_n=0. Takes effect on that clock edge.
- Read:
  - readdata <= mux(address) every cycle, regardless of chipselect.
  - Fixed 1-cycle read latency; reads have no side effects.
- Simultaneous press event and W1C of the same EDGE_CAP bit: the set wins, and the bit stays 1.
- irq = |(edge_cap & irq_mask), registered (1 cycle after edge_cap/irq_mask change). Unmasking an already-set edge asserts irq on the following cycle.
- Mid-debounce reset returns all state to reset values immediately; no pending event survives.

Optional Feature:
- Macro PB_PRESS_COUNT_EN.
- Defined:
  - Per-button 8-bit press counter, incremented on each press event and saturating at 255.
  - Offset 3 reads {counter[WIDTH-1], ..., counter[0]} packed from bit 0 in 8-bit lanes; unused bits read 0.
  - Any write to offset 3 clears all counters. A simultaneous press event on a bit leaves that counter = 1.
  - Counters reset to 0.
- Undefined: no counters are instantiated, offset 3 reads 0, and writes to it are ignored.

Test Plan (DEBOUNCE_CYCLES=4, WIDTH=2):
- Reset, then read offsets 0..3 -> all 0; irq=0.
- Drive in_port=2'b10, hold -> DATA reads 0x1 after exactly 6 edges. EDGE_CAP = 0x1; irq stays 0 (mask 0).
- Bounce: in_port[1] toggles 0/1 every 3 cycles for 30 cycles, then held 1 -> DATA bit1 never sets; EDGE_CAP bit1 stays 0.
- Write IRQ_MASK=0x3 with EDGE_CAP=0x1 -> irq=1 the next cycle. Write EDGE_CAP=0x1 -> irq=0 the next cycle.
- Press event on bit0 coincides with a W1C write of 0x1 to EDGE_CAP -> EDGE_CAP reads 0x1 and irq remains 1.
- With PB_PRESS_COUNT_EN: 300 debounced presses on button 0 and 3 on button 1 -> offset 3 reads 0x03FF. A write to offset 3 -> reads 0x0000.

Source files
------------

// File: rtl/pb_debounce_irq_ctrl.sv
// Pushbutton debouncer with sticky press capture and a maskable irq on Avalon-MM.
// Optional per-button press counters at offset 3 when PB_PRESS_COUNT_EN is defined.
module pb_debounce_irq_ctrl #(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
    logic             irq_q, irq_d;
    logic [31:0]      readdata_q, readdata_d;

    logic [WIDTH-1:0] press;
    logic [WIDTH-1:0] w1c;
    logic [3:0]       sel;
    logic             wr;
    logic [31:0]      cnt_rd;
    logic             unused_wdata;

    assign wr  = chipselect & ~write_n;
    assign sel = 4'b0001 << address;

    // Two-flop synchroniser followed by per-bit debounce counters.
    always_comb begin
        sync1_d  = in_port;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
        // A press is the accepted 1 -> 0 transition of the debounced level.
        press = stable_q & ~stable_d;
    end

    // Register file next-state, irq and the registered read mux.
    always_comb begin
        mask_d = mask_q;
        if (wr && sel[1]) begin
            mask_d = writedata[WIDTH-1:0];
        end
        w1c = '0;
        if (wr && sel[2]) begin
            w1c = writedata[WIDTH-1:0];
        end
        // A press on the same edge as a clear keeps the bit set.
        edge_cap_d = (edge_cap_q & ~w1c) | press;
        irq_d      = |(edge_cap_q & mask_q);
        readdata_d = '0;
        unique case (1'b1)
            sel[0]:  readdata_d[WIDTH-1:0] = ~stable_q;
            sel[1]:  readdata_d[WIDTH-1:0] = mask_q;
            sel[2]:  readdata_d[WIDTH-1:0] = edge_cap_q;
            default: readdata_d = cnt_rd;
        endcase
    end

`ifdef PB_PRESS_COUNT_EN
    logic [7:0]  pcnt_q [WIDTH];
    logic [7:0]  pcnt_d [WIDTH];
    logic [63:0] lanes;
    logic        wr_cnt;

    assign wr_cnt = wr & sel[3];

    // Saturating press counters; a clear coinciding with a press leaves 1.
    always_comb begin
        lanes = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pcnt_d[i] = pcnt_q[i];
            if (wr_cnt) begin
                pcnt_d[i] = '0;
            end
            if (press[i]) begin
                if (wr_cnt) begin
                    pcnt_d[i] = 8'd1;
                end else if (pcnt_q[i] != 8'hFF) begin
                    pcnt_d[i] = pcnt_q[i] + 8'd1;
                end
            end
            lanes[8*i +: 8] = pcnt_q[i];
        end
    end

    assign cnt_rd       = lanes[31:0];
    assign unused_wdata = ^{writedata[31:WIDTH], lanes[63:32]};

    // Press counter state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                pcnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                pcnt_q[i] <= pcnt_d[i];
            end
        end
    end
`else
    assign cnt_rd       = '0;
    assign unused_wdata = ^writedata[31:WIDTH];
`endif

    // Core state: synchroniser, debounce, registers and outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= '1;
            sync2_q    <= '1;
            stable_q   <= '1;
            mask_q     <= '0;
            edge_cap_q <= '0;
            irq_q      <= 1'b0;
            readdata_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            stable_q   <= stable_d;
            mask_q     <= mask_d;
            edge_cap_q <= edge_cap_d;
            irq_q      <= irq_d;
            readdata_q <= readdata_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_pb_debounce_irq_ctrl.sv
// Directed bench for pb_debounce_irq_ctrl with WIDTH=2, DEBOUNCE_CYCLES=4.
// Covers debounce latency, bounce rejection, W1C, irq masking and press counters.
module tb_pb_debounce_irq_ctrl;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [1:0]  in_port;
    logic        irq;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef PB_PRESS_COUNT_EN
    localparam logic [31:0] CNT_AFTER_FIRST = 32'h0000_0001;
`else
    localparam logic [31:0] CNT_AFTER_FIRST = 32'h0000_0000;
`endif

    typedef struct packed {
        logic [1:0]  addr;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t vt [14];

    pb_debounce_irq_ctrl #(
        .WIDTH(2),
        .DEBOUNCE_CYCLES(4),
        .CNT_W(4)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .readdata(readdata),
        .in_port(in_port),
        .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    // One bus cycle; readdata afterwards reflects state before this edge.
    task automatic bus(input logic [1:0] a, input logic w,
                       input logic [31:0] d);
        address    = a;
        chipselect = w;
        write_n    = ~w;
        writedata  = d;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    initial begin
        // Reset reads, then register accesses with button 0 held pressed.
        vt[0]  = '{2'd0, 1'b0, 32'h0,     32'h0,           1'b0};
        vt[1]  = '{2'd1, 1'b0, 32'h0,     32'h0,           1'b0};
        vt[2]  = '{2'd2, 1'b0, 32'h0,     32'h0,           1'b0};
        vt[3]  = '{2'd3, 1'b0, 32'h0,     32'h0,           1'b0};
        vt[4]  = '{2'd1, 1'b1, 32'hFF,    32'h0,           1'b0};
        vt[5]  = '{2'd1, 1'b0, 32'h0,     32'h3,           1'b1};
        vt[6]  = '{2'd2, 1'b1, 32'h2,     32'h1,           1'b1};
        vt[7]  = '{2'd2, 1'b0, 32'h0,     32'h1,           1'b1};
        vt[8]  = '{2'd2, 1'b1, 32'h1,     32'h1,           1'b1};
        vt[9]  = '{2'd2, 1'b0, 32'h0,     32'h0,           1'b0};
        vt[10] = '{2'd0, 1'b1, 32'hFFFF,  32'h1,           1'b0};
        vt[11] = '{2'd0, 1'b0, 32'h0,     32'h1,           1'b0};
        vt[12] = '{2'd3, 1'b1, 32'h1234,  CNT_AFTER_FIRST, 1'b0};
        vt[13] = '{2'd3, 1'b0, 32'h0,     32'h0,           1'b0};

        reset_n    = 1'b0;
        in_port    = 2'b11;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        repeat (3) tick();
        chk("rst_readdata", readdata, 32'h0);
        chk("rst_irq", {31'b0, irq}, 32'h0);
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) begin
            bus(vt[i].addr, vt[i].wr, vt[i].wdata);
            chk($sformatf("vec%0d_rd", i), readdata, vt[i].exp_rd);
            chk($sformatf("vec%0d_irq", i), {31'b0, irq},
                {31'b0, vt[i].exp_irq});
        end

        // Press button 0: stable updates on edge 6, visible one edge later.
        address = 2'd0;
        in_port = 2'b10;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 6) chk("data_edge6_old", readdata, 32'h0);
            if (k == 7) chk("data_edge7_new", readdata, 32'h1);
        end
        bus(2'd2, 1'b0, 32'h0);
        chk("edge_cap_press0", readdata, 32'h1);
        chk("irq_masked", {31'b0, irq}, 32'h0);

        // Bounce on button 1 with runs of 3 cycles never reaches expiry.
        address = 2'd0;
        for (int c = 0; c < 30; c++) begin
            in_port = {((c / 3) % 2 == 1), 1'b0};
            tick();
            chk($sformatf("bounce_data_c%0d", c), readdata, 32'h1);
        end
        in_port = 2'b10;
        repeat (10) tick();
        bus(2'd0, 1'b0, 32'h0);
        chk("bounce_data_end", readdata, 32'h1);
        bus(2'd2, 1'b0, 32'h0);
        chk("bounce_edge_cap", readdata, 32'h1);

        for (int i = 4; i < 14; i++) begin
            bus(vt[i].addr, vt[i].wr, vt[i].wdata);
            chk($sformatf("vec%0d_rd", i), readdata, vt[i].exp_rd);
            chk($sformatf("vec%0d_irq", i), {31'b0, irq},
                {31'b0, vt[i].exp_irq});
        end

        // Re-press button 0 with the mask open: irq asserts.
        in_port = 2'b11;
        repeat (8) tick();
        in_port = 2'b10;
        repeat (8) tick();
        bus(2'd2, 1'b0, 32'h0);
        chk("edge_cap_repress", readdata, 32'h1);
        chk("irq_repress", {31'b0, irq}, 32'h1);

        // Press lands on the same edge as a W1C of bit 0: set wins.
        in_port = 2'b11;
        repeat (8) tick();
        in_port = 2'b10;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk($sformatf("irq_pre_w1c_%0d", k), {31'b0, irq}, 32'h1);
        end
        bus(2'd2, 1'b1, 32'h1);
        chk("irq_w1c_edge", {31'b0, irq}, 32'h1);
        bus(2'd2, 1'b0, 32'h0);
        chk("edge_cap_set_wins", readdata, 32'h1);
        chk("irq_set_wins", {31'b0, irq}, 32'h1);
        tick();
        chk("irq_set_wins_hold", {31'b0, irq}, 32'h1);

`ifdef PB_PRESS_COUNT_EN
        bus(2'd3, 1'b1, 32'h0);
        bus(2'd3, 1'b0, 32'h0);
        chk("pcnt_cleared", readdata, 32'h0);
        for (int p = 0; p < 300; p++) begin
            in_port = 2'b11;
            repeat (8) tick();
            in_port = (p < 3) ? 2'b00 : 2'b10;
            repeat (8) tick();
        end
        in_port = 2'b10;
        bus(2'd3, 1'b0, 32'h0);
        chk("pcnt_300_3", readdata, 32'h0000_03FF);
        bus(2'd3, 1'b1, 32'h0);
        bus(2'd3, 1'b0, 32'h0);
        chk("pcnt_wr_clear", readdata, 32'h0);
        in_port = 2'b11;
        repeat (8) tick();
        in_port = 2'b10;
        repeat (5) tick();
        bus(2'd3, 1'b1, 32'h0);
        bus(2'd3, 1'b0, 32'h0);
        chk("pcnt_clear_vs_press", readdata, 32'h1);
`endif

        // Reset in the middle of a debounce run drops everything.
        in_port = 2'b11;
        repeat (8) tick();
        in_port = 2'b10;
        repeat (4) tick();
        chk("irq_before_rst", {31'b0, irq}, 32'h1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_irq", {31'b0, irq}, 32'h0);
        chk("mid_rst_rd", readdata, 32'h0);
        in_port = 2'b11;
        tick();
        reset_n = 1'b1;
        repeat (10) tick();
        bus(2'd2, 1'b0, 32'h0);
        chk("post_rst_edge_cap", readdata, 32'h0);
        bus(2'd1, 1'b0, 32'h0);
        chk("post_rst_mask", readdata, 32'h0);
        bus(2'd0, 1'b0, 32'h0);
        chk("post_rst_data", readdata, 32'h0);
        chk("post_rst_irq", {31'b0, irq}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
